reg_file_32x32: RTL and testbench
=================================

// Module: reg_file_32x32
// PURPOSE
//  MIPS general-purpose register file: 32 x 32-bit registers, two async read ports, one sync write port.
//  Sits directly downstream of the 5-bit 2:1 write-register-select mux (rt/rd); that mux's output drives W_Addr.
//  Read ports feed the ALU operand path; the write port takes write-back data.
// PARAMETERS
//  DATA_W   32  register width in bits
//  ADDR_W   5   register address width; depth = 2**ADDR_W = 32
// PORTS
//  clk       in   1       system clock; all writes on rising edge
//  rst_n     in   1       reset, asynchronous, active-low; clears every register
//  RegWrite  in   1       write enable, sampled on rising clk
//  W_Addr    in   ADDR_W  write register number (from write-select mux)
//  W_Data    in   DATA_W  write-back data
//  R_Addr_A  in   ADDR_W  read port A register number (rs)
//  R_Addr_B  in   ADDR_W  read port B register number (rt)
//  R_Data_A  out  DATA_W  read port A data
//  R_Data_B  out  DATA_W  read port B data
// BEHAVIOUR
//  - Reset: rst_n=0 immediately clears regs[0..31] to 0, independent of clk; R_Data_A/B = 0 while held.
//  - Reset deasserted mid-cycle: the first write is accepted on the next rising edge with rst_n=1.
//  - Write: on posedge clk with rst_n=1, RegWrite=1, W_Addr!=0 -> regs[W_Addr] <= W_Data. One-cycle latency.
//  - RegWrite=0: no register changes; W_Addr/W_Data are ignored.
//  - $0: writes to W_Addr=0 are discarded; regs[0] is constant 0. R_Addr=0 always reads 0, bypass included.
//  - Read: combinational, zero latency. R_Data_x = regs[R_Addr_x]; both ports are independent.
//  - A and B may address the same register: both return the same value.
//  - Read/write same cycle, same nonzero address: result depends on the optional feature below.
//  - No X propagation: every register is defined after reset; out-of-range addresses cannot occur (5-bit).
// CONFIGURATION
//  REG_FILE_BYPASS_EN defined:
//   If RegWrite=1, W_Addr!=0 and R_Addr_x==W_Addr, R_Data_x = W_Data in the same cycle (write-through).
//   This supports a single-cycle write-back/read overlap.
//  REG_FILE_BYPASS_EN undefined:
//   R_Data_x = the old regs[R_Addr_x] until after the edge; the new value is visible from the next cycle.
// STRUCTURE
//  Shared package cpu_defs_pkg holds DATA_W=32, ADDR_W=5, REG_NUM=32 and REG_ZERO=5'd0.
//  The same package holds the named register constants (REG_SP=29, REG_RA=31) used by the decode and testbench.
//  Sub-module reg_file_rd_port: read mux plus $0 masking plus optional bypass, instantiated twice (A, B).
//  The storage array and write logic stay in the top module.
// TESTING
//  1 Reset: write 0xDEADBEEF to r5, pulse rst_n low between edges -> R_Data_A(r5)=0 at once, without a clk edge.
//  2 Write/read: write r1=0x12345678 and r31=0xFFFFFFFF; read A=r1, B=r31 next cycle -> 0x12345678, 0xFFFFFFFF.
//  3 $0: RegWrite=1, W_Addr=0, W_Data=0xA5A5A5A5 -> R_Data_A(r0)=0 after the edge, including under bypass.
//  4 Write disabled: RegWrite=0, W_Addr=7, W_Data=0x1 -> r7 keeps its prior value 0x00000055.
//  5 Same-cycle hazard: r9=0x11, then write r9=0x22 while reading r9 -> BYPASS_EN: 0x22 before the edge;
//    otherwise 0x11 before the edge and 0x22 after it.
//  6 Sweep: write r(i)=i*0x01010101 for i=1..31, read pairs (i, 32-i) -> all match; r0 reads 0.

Source files
------------

// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: datapath widths and named architectural registers.
package cpu_defs_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned ADDR_W  = 5;
   localparam int unsigned REG_NUM = 2 ** ADDR_W;

   localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
   localparam logic [ADDR_W-1:0] REG_SP   = 5'd29;
   localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/reg_file_rd_port.sv
// One asynchronous read port of the register file: array mux, $0 forced to zero,
// and optional same-cycle write-through (macro REG_FILE_BYPASS_EN).
module reg_file_rd_port
   import cpu_defs_pkg::*;
(
   input  logic [DATA_W-1:0] regs_i [REG_NUM],
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   output logic [DATA_W-1:0] rd_data_o
);

`ifndef REG_FILE_BYPASS_EN
   // Write port only matters when write-through is built in.
   logic unused_wr;
   assign unused_wr = ^{wr_en_i, wr_addr_i, wr_data_i};
`endif

   // Select stored value, optionally overridden by in-flight write, $0 always wins.
   always_comb begin
      rd_data_o = regs_i[rd_addr_i];
`ifdef REG_FILE_BYPASS_EN
      if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
         rd_data_o = wr_data_i;
      end
`endif
      if (rd_addr_i == REG_ZERO) begin
         rd_data_o = '0;
      end
   end

endmodule

// File: rtl/reg_file_32x32.sv
// MIPS general-purpose register file: 32 x 32-bit, two async read ports, one sync write port.
// Optional write-through bypass on the read ports: define REG_FILE_BYPASS_EN.
module reg_file_32x32
   import cpu_defs_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] W_Addr,
   input  logic [DATA_W-1:0] W_Data,
   input  logic [ADDR_W-1:0] R_Addr_A,
   input  logic [ADDR_W-1:0] R_Addr_B,
   output logic [DATA_W-1:0] R_Data_A,
   output logic [DATA_W-1:0] R_Data_B
);

   logic [DATA_W-1:0] regs_q [REG_NUM];
   logic [DATA_W-1:0] regs_d [REG_NUM];
   logic              wr_en;

   // Writes to $0 are dropped here so regs_q[0] never leaves zero.
   assign wr_en = RegWrite && (W_Addr != REG_ZERO);

   // Next-state of the array: only the addressed register changes.
   always_comb begin
      regs_d = regs_q;
      if (wr_en) begin
         regs_d[W_Addr] = W_Data;
      end
   end

   // Storage with asynchronous clear of every register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   reg_file_rd_port u_rd_port_a (
      .regs_i    (regs_q),
      .rd_addr_i (R_Addr_A),
      .wr_en_i   (wr_en),
      .wr_addr_i (W_Addr),
      .wr_data_i (W_Data),
      .rd_data_o (R_Data_A)
   );

   reg_file_rd_port u_rd_port_b (
      .regs_i    (regs_q),
      .rd_addr_i (R_Addr_B),
      .wr_en_i   (wr_en),
      .wr_addr_i (W_Addr),
      .wr_data_i (W_Data),
      .rd_data_o (R_Data_B)
   );

endmodule

// File: tb/tb_reg_file_32x32.sv
// Scoreboard bench for reg_file_32x32: directed scenarios plus random traffic,
// checked against an array model of the architectural registers.
module tb_reg_file_32x32;
   import cpu_defs_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              RegWrite;
   logic [ADDR_W-1:0] W_Addr;
   logic [DATA_W-1:0] W_Data;
   logic [ADDR_W-1:0] R_Addr_A;
   logic [ADDR_W-1:0] R_Addr_B;
   logic [DATA_W-1:0] R_Data_A;
   logic [DATA_W-1:0] R_Data_B;

   reg_file_32x32 dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .RegWrite (RegWrite),
      .W_Addr   (W_Addr),
      .W_Data   (W_Data),
      .R_Addr_A (R_Addr_A),
      .R_Addr_B (R_Addr_B),
      .R_Data_A (R_Data_A),
      .R_Data_B (R_Data_B)
   );

   always #5 clk = ~clk;

   typedef struct {
      string             name;
      logic [ADDR_W-1:0] ra;
      logic [ADDR_W-1:0] rb;
      logic [DATA_W-1:0] ea;
      logic [DATA_W-1:0] eb;
   } exp_t;

   exp_t              exp_q[$];
   event              push_ev;
   logic [DATA_W-1:0] model [REG_NUM];
   bit                bypass;
   int                n_checks = 0;
   int                n_fail   = 0;

   // Architectural view of a read given what the bench is driving right now.
   function automatic logic [DATA_W-1:0] ref_read(input logic [ADDR_W-1:0] a);
      if (a == 5'd0) return '0;
      if (bypass && RegWrite && (W_Addr == a)) return W_Data;
      return model[a];
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 32; i++) model[i] = '0;
   endtask

   task automatic expect_now(input string name);
      exp_t e;
      e.name = name;
      e.ra   = R_Addr_A;
      e.rb   = R_Addr_B;
      e.ea   = ref_read(R_Addr_A);
      e.eb   = ref_read(R_Addr_B);
      exp_q.push_back(e);
      -> push_ev;
      #1;
   endtask

   // Drive one cycle's inputs, check the pre-edge reads, then commit the write in the model.
   task automatic cycle(input logic we, input logic [ADDR_W-1:0] wa, input logic [DATA_W-1:0] wd,
                        input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb,
                        input string name);
      @(negedge clk);
      RegWrite = we;
      W_Addr   = wa;
      W_Data   = wd;
      R_Addr_A = ra;
      R_Addr_B = rb;
      #2;
      expect_now(name);
      @(posedge clk);
      if (rst_n && we && (wa != 5'd0)) model[wa] = wd;
   endtask

   task automatic read_only(input logic [ADDR_W-1:0] ra, input logic [ADDR_W-1:0] rb,
                            input string name);
      cycle(1'b0, 5'($urandom), $urandom, ra, rb, name);
   endtask

   // Monitor: pops each expectation and compares both ports.
   initial begin
      exp_t e;
      forever begin
         @(push_ev);
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (R_Data_A !== e.ea) begin
               n_fail++;
               $display("FAIL %s port A r%0d: got %h expected %h", e.name, e.ra, R_Data_A, e.ea);
            end
            n_checks++;
            if (R_Data_B !== e.eb) begin
               n_fail++;
               $display("FAIL %s port B r%0d: got %h expected %h", e.name, e.rb, R_Data_B, e.eb);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic              we;
      logic [ADDR_W-1:0] wa, ra, rb;
`ifdef REG_FILE_BYPASS_EN
      bypass = 1'b1;
`else
      bypass = 1'b0;
`endif
      clear_model();
      rst_n    = 1'b0;
      RegWrite = 1'b0;
      W_Addr   = '0;
      W_Data   = '0;
      R_Addr_A = 5'd5;
      R_Addr_B = REG_RA;
      #3;
      expect_now("reset_held");

      // Release mid-cycle; a write set up now must land on the very next edge.
      #8;
      rst_n    = 1'b1;
      #1;
      RegWrite = 1'b1;
      W_Addr   = 5'd3;
      W_Data   = 32'h0000_0033;
      @(posedge clk);
      model[3] = 32'h0000_0033;

      cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd3, "write_r5");
      read_only(5'd5, 5'd3, "read_r5_r3");

      // Asynchronous reset pulse strictly between clock edges.
      @(negedge clk);
      RegWrite = 1'b0;
      R_Addr_A = 5'd5;
      R_Addr_B = 5'd3;
      #1;
      rst_n = 1'b0;
      #1;
      clear_model();
      expect_now("async_reset_r5");
      rst_n = 1'b1;
      read_only(5'd5, 5'd3, "after_reset");

      cycle(1'b1, 5'd1, 32'h1234_5678, 5'd1, 5'd31, "write_r1");
      cycle(1'b1, 5'd31, 32'hFFFF_FFFF, 5'd1, 5'd31, "write_r31");
      read_only(5'd1, 5'd31, "read_r1_r31");

      cycle(1'b1, 5'd0, 32'hA5A5_A5A5, 5'd0, 5'd0, "write_r0");
      read_only(5'd0, 5'd1, "read_r0_after");

      cycle(1'b1, 5'd7, 32'h0000_0055, 5'd7, 5'd1, "write_r7");
      cycle(1'b0, 5'd7, 32'h0000_0001, 5'd7, 5'd7, "we0_r7");
      read_only(5'd7, 5'd7, "r7_kept");

      cycle(1'b1, 5'd9, 32'h0000_0011, 5'd1, 5'd2, "write_r9");
      cycle(1'b1, 5'd9, 32'h0000_0022, 5'd9, 5'd9, "hazard_pre");
      read_only(5'd9, 5'd9, "hazard_post");

      for (int i = 1; i < 32; i++) begin
         cycle(1'b1, 5'(i), i * 32'h0101_0101, 5'(i), 5'(32 - i), "sweep_write");
      end
      for (int i = 1; i < 32; i++) begin
         read_only(5'(i), 5'(32 - i), "sweep_read");
      end
      read_only(5'd0, REG_SP, "sweep_r0_sp");

      for (int n = 0; n < 300; n++) begin
         we = 1'($urandom);
         wa = 5'($urandom);
         ra = 5'($urandom);
         rb = 5'($urandom);
         if ($urandom_range(3) == 0) ra = wa;
         if ($urandom_range(5) == 0) rb = wa;
         cycle(we, wa, $urandom, ra, rb, "random");
      end

      @(negedge clk);
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations unchecked, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
